// File: rtl/point_cloud_pkg.sv
// Shared definitions for the LiDAR point-cloud receive path: sizes, field offsets,
// the formatted point layout and the disassembler FSM states.
package point_cloud_pkg;

  localparam int POINT_W          = 128;
  localparam int POINTS_PER_BLOCK = 4;
  localparam int BLOCK_W          = POINT_W * POINTS_PER_BLOCK;
  localparam int SLOT_W           = 2;
  localparam int CNT_W            = 3;
  localparam int COORD_W          = 32;
  localparam int CHAN_W           = 8;

  localparam int X_LSB = 96;
  localparam int Y_LSB = 64;
  localparam int Z_LSB = 32;
  localparam int R_LSB = 24;
  localparam int G_LSB = 16;
  localparam int B_LSB = 8;
  localparam int I_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [CHAN_W-1:0]  R;
    logic [CHAN_W-1:0]  G;
    logic [CHAN_W-1:0]  B;
    logic [CHAN_W-1:0]  intensity;
  } point_t;

  typedef enum logic {IDLE, EMIT} disasm_state_t;

  // Counts above the block capacity still emit a full block.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
    return (cnt > CNT_W'(POINTS_PER_BLOCK)) ? CNT_W'(POINTS_PER_BLOCK) : cnt;
  endfunction

endpackage

// File: rtl/point_unformatter.sv
// Combinational split of one formatted point into its coordinate and colour fields;
// the field order mirrors the point formatter exactly.
module point_unformatter
  import point_cloud_pkg::*;
(
  input  point_t              pt,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COORD_W-1:0]  z,
  output logic [CHAN_W-1:0]   R,
  output logic [CHAN_W-1:0]   G,
  output logic [CHAN_W-1:0]   B,
  output logic [CHAN_W-1:0]   intensity
);

  logic [POINT_W-1:0] bits;

  assign bits      = pt;
  assign x         = bits[X_LSB +: COORD_W];
  assign y         = bits[Y_LSB +: COORD_W];
  assign z         = bits[Z_LSB +: COORD_W];
  assign R         = bits[R_LSB +: CHAN_W];
  assign G         = bits[G_LSB +: CHAN_W];
  assign B         = bits[B_LSB +: CHAN_W];
  assign intensity = bits[I_LSB +: CHAN_W];

endmodule

// File: rtl/point_cloud_disassembler.sv
// Unpacks 512-bit point blocks into one point per handshake, with back-to-back
// block chaining, a sticky bad-count flag and a running point counter.
module point_cloud_disassembler
  import point_cloud_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [BLOCK_W-1:0]  block_data,
  input  logic [CNT_W-1:0]    block_count,
  input  logic                block_valid,
  output logic                block_ready,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COORD_W-1:0]  z,
  output logic [CHAN_W-1:0]   R,
  output logic [CHAN_W-1:0]   G,
  output logic [CHAN_W-1:0]   B,
  output logic [CHAN_W-1:0]   intensity,
  output logic                point_valid,
  input  logic                point_ready,
  output logic                point_last,
  output logic                count_err,
  output logic [31:0]         points_emitted
);

  if (BLOCK_W != POINT_W * POINTS_PER_BLOCK) begin : g_blk_chk
    $error("BLOCK_W must equal POINT_W*POINTS_PER_BLOCK");
  end
  if ($bits(point_t) != POINT_W) begin : g_pt_chk
    $error("point_t width must equal POINT_W");
  end

  disasm_state_t                           state_q, state_d;
  logic [POINTS_PER_BLOCK-1:0][POINT_W-1:0] hold_q;
  logic [SLOT_W-1:0]                       slot_q;
  logic [CNT_W-1:0]                        eff_cnt_q;
  logic [CNT_W-1:0]                        eff_in;
  logic                                    accept;
  logic                                    fire;
  point_t                                  cur_pt;

  assign eff_in = sat_count(block_count);

  // Fields come only from registered hold/slot, never straight from block_data.
  assign cur_pt = point_t'(hold_q[slot_q]);

  point_unformatter u_unfmt (
    .pt        (cur_pt),
    .x         (x),
    .y         (y),
    .z         (z),
    .R         (R),
    .G         (G),
    .B         (B),
    .intensity (intensity)
  );

  always_comb begin
    state_d     = state_q;
    point_valid = (state_q == EMIT);
    point_last  = point_valid && ({1'b0, slot_q} == (eff_cnt_q - CNT_W'(1)));
    // The final point's handshake frees the hold register, so a new block can land then.
    block_ready = !reset && ((state_q == IDLE) || (point_last && point_ready));
    accept      = block_valid && block_ready;
    fire        = point_valid && point_ready;
    if (accept)
      state_d = (eff_in == '0) ? IDLE : EMIT;
    else if (fire && point_last)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      slot_q         <= '0;
      eff_cnt_q      <= '0;
      count_err      <= 1'b0;
      points_emitted <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_q    <= block_data;
        eff_cnt_q <= eff_in;
        slot_q    <= '0;
        if (block_count > CNT_W'(POINTS_PER_BLOCK))
          count_err <= 1'b1;
      end else if (fire && !point_last) begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      if (fire)
        points_emitted <= points_emitted + 32'd1;
    end
  end

endmodule
